// File: rtl/matrix_op_controller.sv
// Sequencer for the matrix coprocessor: fetches A (and B), runs the ALU,
// writes the result back to the single-port matrix RAM and reports done/error.
module matrix_op_controller #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 256,
   parameter int RD_LAT      = 1,
   parameter int ALU_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        opcode,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [ADDR_W-1:0] addr_c,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_A,
      S_WAIT_A,
      S_RD_B,
      S_WAIT_B,
      S_EXEC,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [2:0] OP_TRN   = 3'd3;
   localparam logic [2:0] OP_NEG   = 3'd4;
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
   localparam logic [7:0] TO_LAST  = 8'(ALU_TIMEOUT - 1);

   state_t            state_q;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_b_q;
   logic [ADDR_W-1:0] addr_c_q;
   logic [1:0]        lat_q;
   logic [7:0]        cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_wren_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] alu_a_q;
   logic [DATA_W-1:0] alu_b_q;
   logic              alu_start_q;
   logic              op_unary;

   assign op_unary = (op_q == OP_TRN) || (op_q == OP_NEG);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         addr_b_q    <= '0;
         addr_c_q    <= '0;
         lat_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wren_q  <= 1'b0;
         mem_wdata_q <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_start_q <= 1'b0;
      end else begin
         // Pulse outputs default low; the transitions below raise them for one cycle.
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         mem_wren_q  <= 1'b0;
         alu_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q     <= opcode;
                  addr_b_q <= addr_b;
                  addr_c_q <= addr_c;
                  if (opcode <= OP_NEG) begin
                     mem_addr_q <= addr_a;
                     busy_q     <= 1'b1;
                     state_q    <= S_RD_A;
                  end else begin
                     error_q <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            S_RD_A: begin
               lat_q   <= '0;
               state_q <= S_WAIT_A;
            end
            S_WAIT_A: begin
               if (lat_q == LAT_LAST) begin
                  alu_a_q <= mem_rdata;
                  if (op_unary) begin
                     alu_b_q     <= '0;
                     alu_start_q <= 1'b1;
                     cnt_q       <= '0;
                     state_q     <= S_EXEC;
                  end else begin
                     mem_addr_q <= addr_b_q;
                     state_q    <= S_RD_B;
                  end
               end else begin
                  lat_q <= lat_q + 2'd1;
               end
            end
            S_RD_B: begin
               lat_q   <= '0;
               state_q <= S_WAIT_B;
            end
            S_WAIT_B: begin
               if (lat_q == LAT_LAST) begin
                  alu_b_q     <= mem_rdata;
                  alu_start_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= S_EXEC;
               end else begin
                  lat_q <= lat_q + 2'd1;
               end
            end
            S_EXEC: begin
               // Counter stops at TO_LAST, so it cannot wrap.
               if (alu_done) begin
                  mem_wdata_q <= alu_result;
                  mem_addr_q  <= addr_c_q;
                  mem_wren_q  <= 1'b1;
                  state_q     <= S_WRITE;
               end else if (cnt_q == TO_LAST) begin
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_WRITE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wren  = mem_wren_q;
   assign mem_wdata = mem_wdata_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = op_q;
   assign alu_start = alu_start_q;

endmodule

// File: tb/tb_matrix_op_controller.sv
// Bench for matrix_op_controller: RAM and ALU models around an RD_LAT=1 and an
// RD_LAT=2 instance, a table of instructions with hand-computed timing, and reset sequences.
module tb_matrix_op_controller;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // RD_LAT=1 instance
   logic         start;
   logic [2:0]   opcode;
   logic [7:0]   addr_a, addr_b, addr_c;
   logic         busy, done, error, mem_wren, alu_start, alu_done;
   logic [7:0]   mem_addr;
   logic [255:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_result;
   logic [2:0]   alu_op;

   // RD_LAT=2 instance
   logic         start2;
   logic [2:0]   opcode2;
   logic [7:0]   addr_a2, addr_b2, addr_c2;
   logic         busy2, done2, error2, mem_wren2, alu_start2, alu_done2;
   logic [7:0]   mem_addr2;
   logic [255:0] mem_wdata2, mem_rdata2, alu_a2, alu_b2, alu_result2;
   logic [2:0]   alu_op2;

   matrix_op_controller #(.RD_LAT(1)) u_dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
      .busy(busy), .done(done), .error(error),
      .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result)
   );

   matrix_op_controller #(.RD_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .opcode(opcode2),
      .addr_a(addr_a2), .addr_b(addr_b2), .addr_c(addr_c2),
      .busy(busy2), .done(done2), .error(error2),
      .mem_addr(mem_addr2), .mem_wren(mem_wren2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_start(alu_start2),
      .alu_done(alu_done2), .alu_result(alu_result2)
   );

   // ALU reference behaviour
   function automatic logic [255:0] alu_fn(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b);
      case (op)
         3'd0:    alu_fn = a + b;
         3'd1:    alu_fn = a - b;
         3'd2:    alu_fn = a * b;
         3'd3:    alu_fn = {a[127:0], a[255:128]};
         3'd4:    alu_fn = '0 - a;
         default: alu_fn = '0;
      endcase
   endfunction

   // RAM models; the bench preloads words through the ld_* port
   logic [255:0] ram1 [256];
   logic [255:0] ram2 [256];
   logic [255:0] rd2_p;
   logic         ld1 = 1'b0, ld2 = 1'b0;
   logic [7:0]   ld_addr;
   logic [255:0] ld_data;

   always @(posedge clk) begin
      if (ld1) ram1[ld_addr] <= ld_data;
      else if (mem_wren) ram1[mem_addr] <= mem_wdata;
      mem_rdata <= ram1[mem_addr];
   end

   always @(posedge clk) begin
      if (ld2) ram2[ld_addr] <= ld_data;
      else if (mem_wren2) ram2[mem_addr2] <= mem_wdata2;
      rd2_p      <= ram2[mem_addr2];
      mem_rdata2 <= rd2_p;
   end

   // ALU model: delay 0 answers in the alu_start cycle, delay N answers N cycles later, delay -1 never
   int alu_delay = 0;
   int alu_cd = 0;
   always @(posedge clk) begin
      if (alu_start && alu_delay > 0) alu_cd <= alu_delay;
      else if (alu_cd > 0) alu_cd <= alu_cd - 1;
   end
   assign alu_done    = (alu_delay == 0) ? alu_start : (alu_cd == 1);
   assign alu_result  = alu_fn(alu_op, alu_a, alu_b);
   assign alu_done2   = alu_start2;
   assign alu_result2 = alu_fn(alu_op2, alu_a2, alu_b2);

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_ctrl"}, 256'({busy, done, error, mem_wren, alu_start, alu_op, mem_addr}), '0);
      chk({name, "_wdata"}, mem_wdata, '0);
      chk({name, "_alu_a"}, alu_a, '0);
      chk({name, "_alu_b"}, alu_b, '0);
   endtask

   task automatic load(input bit sel2, input logic [7:0] a, input logic [255:0] d);
      @(negedge clk);
      ld1 = !sel2; ld2 = sel2; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld1 = 1'b0; ld2 = 1'b0;
   endtask

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic scramble_inputs();
      opcode = 3'($urandom_range(0, 7));
      addr_a = 8'($urandom_range(0, 255));
      addr_b = 8'($urandom_range(0, 255));
      addr_c = 8'($urandom_range(0, 255));
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] aa, ab, ac;
      int         delay;
      bit         inject;
      int         e_st, e_wr, e_done, e_err, e_bf, e_bl;
   } vec_t;

   vec_t vecs[9];

   task automatic run_vec(input int idx, input vec_t v);
      logic [255:0] a_exp, b_exp, r_exp, c_before, cap_a, cap_b, wr_data;
      logic [7:0]   wr_addr;
      logic [2:0]   cap_op;
      int done_c, done_n, err_c, wr_c, wr_n, st_c, st_n, bf, bl, bn, rb_n, idle_bad;
      bit fin;
      string tag;
      tag = $sformatf("v%0d", idx);
      a_exp = ram1[v.aa];
      b_exp = (v.op == 3'd3 || v.op == 3'd4) ? '0 : ram1[v.ab];
      r_exp = alu_fn(v.op, a_exp, b_exp);
      c_before = ram1[v.ac];
      alu_delay = v.delay;
      done_c = 0; done_n = 0; err_c = 0; wr_c = 0; wr_n = 0; st_c = 0; st_n = 0;
      bf = 0; bl = 0; bn = 0; rb_n = 0; idle_bad = 0; fin = 0;
      cap_a = '0; cap_b = '0; cap_op = '0; wr_data = '0; wr_addr = '0;
      @(negedge clk);
      start = 1'b1; opcode = v.op; addr_a = v.aa; addr_b = v.ab; addr_c = v.ac;
      @(negedge clk);
      start = 1'b0;
      scramble_inputs();
      for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
         if (busy) begin
            if (bf == 0) bf = cyc;
            bl = cyc; bn++;
            if (mem_addr == v.ab) rb_n++;
         end
         if (alu_start) begin
            st_n++; if (st_c == 0) st_c = cyc;
            cap_a = alu_a; cap_b = alu_b; cap_op = alu_op;
         end
         if (mem_wren) begin
            wr_n++; wr_c = cyc; wr_addr = mem_addr; wr_data = mem_wdata;
         end
         if (done) begin done_n++; if (done_c == 0) done_c = cyc; end
         if (error && err_c == 0) err_c = cyc;
         fin = done || error;
         start = v.inject && (cyc == 3 || fin);
         if (start) begin
            opcode = 3'd0; addr_a = v.ab; addr_b = v.aa; addr_c = v.aa;
         end
         @(negedge clk);
         start = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         if (busy || mem_wren || done || error) idle_bad++;
         @(negedge clk);
      end
      chk({tag, "_done_cycle"}, done_c, v.e_done);
      chk({tag, "_done_count"}, done_n, (v.e_done != 0) ? 1 : 0);
      chk({tag, "_err_cycle"}, err_c, v.e_err);
      chk({tag, "_wr_cycle"}, wr_c, v.e_wr);
      chk({tag, "_wr_count"}, wr_n, (v.e_wr != 0) ? 1 : 0);
      chk({tag, "_start_cycle"}, st_c, v.e_st);
      chk({tag, "_start_count"}, st_n, (v.e_st != 0) ? 1 : 0);
      chk({tag, "_busy_first"}, bf, v.e_bf);
      chk({tag, "_busy_last"}, bl, v.e_bl);
      chk({tag, "_busy_len"}, bn, (v.e_bl != 0) ? v.e_bl - v.e_bf + 1 : 0);
      chk({tag, "_idle_after"}, idle_bad, 0);
      if (v.e_st != 0) begin
         chk({tag, "_alu_a"}, cap_a, a_exp);
         chk({tag, "_alu_b"}, cap_b, b_exp);
         chk({tag, "_alu_op"}, cap_op, v.op);
      end
      if (v.e_wr != 0) begin
         chk({tag, "_wr_addr"}, wr_addr, v.ac);
         chk({tag, "_wr_data"}, wr_data, r_exp);
         chk({tag, "_ram_c"}, ram1[v.ac], r_exp);
      end else begin
         chk({tag, "_ram_c_kept"}, ram1[v.ac], c_before);
      end
      if (v.op == 3'd3 || v.op == 3'd4) chk({tag, "_addr_b_unused"}, rb_n, 0);
   endtask

   initial begin
      logic [255:0] x, y, z;
      int done_c, wr_c, wr_n;
      logic [255:0] wr_data, cap_a, cap_b;
      start = 0; opcode = 0; addr_a = 0; addr_b = 0; addr_c = 0;
      start2 = 0; opcode2 = 0; addr_a2 = 0; addr_b2 = 0; addr_c2 = 0;
      ld_addr = 0; ld_data = 0;

      vecs[0] = '{3'd0, 8'h00, 8'h01, 8'h02,  0, 1'b0, 5,  6,  7,   0, 1,   6};
      vecs[1] = '{3'd3, 8'h05, 8'h09, 8'h05,  0, 1'b0, 3,  4,  5,   0, 1,   4};
      vecs[2] = '{3'd6, 8'h00, 8'h01, 8'h02,  0, 1'b0, 0,  0,  0,   1, 0,   0};
      vecs[3] = '{3'd1, 8'h10, 8'h11, 8'h12, 10, 1'b1, 5, 16, 17,   0, 1,  16};
      vecs[4] = '{3'd4, 8'h03, 8'h40, 8'h07,  0, 1'b1, 3,  4,  5,   0, 1,   4};
      vecs[5] = '{3'd2, 8'h20, 8'h20, 8'h20,  0, 1'b0, 5,  6,  7,   0, 1,   6};
      vecs[6] = '{3'd7, 8'h30, 8'h31, 8'h32,  0, 1'b1, 0,  0,  0,   1, 0,   0};
      vecs[7] = '{3'd1, 8'h30, 8'h31, 8'h32,  3, 1'b0, 5,  9, 10,   0, 1,   9};
      vecs[8] = '{3'd2, 8'h50, 8'h51, 8'h52, -1, 1'b0, 5,  0,  0, 260, 1, 259};

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      chk_zero("post_reset");

      foreach (vecs[i]) begin
         load(1'b0, vecs[i].aa, rnd256());
         load(1'b0, vecs[i].ab, rnd256());
         load(1'b0, vecs[i].ac, rnd256());
      end
      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Reset during WAIT_B: everything clears at once, then a clean rerun
      alu_delay = 0;
      @(negedge clk);
      start = 1'b1; opcode = 3'd0; addr_a = 8'h60; addr_b = 8'h61; addr_c = 8'h62;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wb_busy_before", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk_zero("rst_wb");
      @(negedge clk);
      reset = 1'b0;
      run_vec(9, vecs[0]);

      // Reset during WRITE: the pending write must not land
      z = ram1[8'h22];
      @(negedge clk);
      start = 1'b1; opcode = 3'd0; addr_a = 8'h00; addr_b = 8'h01; addr_c = 8'h22;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_wr_wren_before", mem_wren, 1'b1);
      reset = 1'b1;
      #1;
      chk("rst_wr_wren_async", mem_wren, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      wr_n = 0;
      for (int k = 0; k < 3; k++) begin
         if (done || error || mem_wren) wr_n++;
         @(negedge clk);
      end
      chk("rst_wr_no_pulse", wr_n, 0);
      chk("rst_wr_ram_kept", ram1[8'h22], z);

      // RD_LAT=2 instance, binary add
      x = rnd256(); y = rnd256(); z = rnd256();
      load(1'b1, 8'h20, x);
      load(1'b1, 8'h21, y);
      load(1'b1, 8'h22, z);
      @(negedge clk);
      start2 = 1'b1; opcode2 = 3'd0; addr_a2 = 8'h20; addr_b2 = 8'h21; addr_c2 = 8'h22;
      @(negedge clk);
      start2 = 1'b0; addr_a2 = 8'h22; addr_b2 = 8'h22;
      done_c = 0; wr_c = 0; wr_n = 0; wr_data = '0; cap_a = '0; cap_b = '0;
      for (int cyc = 1; cyc <= 40 && done_c == 0; cyc++) begin
         if (alu_start2) begin cap_a = alu_a2; cap_b = alu_b2; end
         if (mem_wren2) begin wr_n++; wr_c = cyc; wr_data = mem_wdata2; end
         if (done2) done_c = cyc;
         @(negedge clk);
      end
      chk("lat2_alu_a", cap_a, x);
      chk("lat2_alu_b", cap_b, y);
      chk("lat2_wr_cycle", wr_c, 8);
      chk("lat2_wr_count", wr_n, 1);
      chk("lat2_wr_data", wr_data, x + y);
      chk("lat2_done_cycle", done_c, 9);
      chk("lat2_ram_c", ram2[8'h22], x + y);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1);
   end

endmodule
